// File: rtl/bg_pkg.sv
// Shared definitions for the starfield background scroll controller.
package bg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_DECEL = 3'd3,
    ST_HALT  = 3'd4
  } bg_state_e;

  localparam int MAX_X_DEF = 640;
  localparam int MAX_Y_DEF = 480;

  // Fibonacci taps 8,6,5,4 -> bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/bg_frame_sync.sv
// Frame-start pulse from the VGA counters and the twinkle frame divider.
module bg_frame_sync
  import bg_pkg::*;
#(
  parameter int MAX_Y          = MAX_Y_DEF,
  parameter int TWINKLE_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] hc,
  input  logic [9:0] vc,
  input  logic       run,
  output logic       frame_tick,
  output logic       twinkle_step
);

  localparam logic [9:0] FRAME_LINE = 10'(MAX_Y);
  localparam logic [7:0] DIV_LAST   = 8'(TWINKLE_FRAMES - 1);

  logic       cond;
  logic       cond_d;
  logic [7:0] div_cnt;

  assign cond = (hc == 10'd0) && (vc == FRAME_LINE);

  // Registered rising-edge detect: one pulse even if the counters dwell on the start pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      cond_d     <= 1'b0;
      frame_tick <= 1'b0;
      div_cnt    <= 8'd0;
    end else begin
      cond_d     <= cond;
      frame_tick <= cond & ~cond_d;
      if (frame_tick && run) begin
        div_cnt <= (div_cnt == DIV_LAST) ? 8'd0 : div_cnt + 8'd1;
      end
    end
  end

  assign twinkle_step = frame_tick & run & (div_cnt == DIV_LAST);

endmodule

// File: rtl/bg_scroll_ctrl.sv
// Scroll sequencer: remaps vc by a per-frame offset and steps the twinkle mask.
//   state | meaning
//   IDLE  | waiting for start, offset held at 0
//   RUN   | offset advances by latched speed each frame, twinkle active
//   PAUSE | offset, speed and twinkle frozen
//   DECEL | speed ramps down to 0 after game over
//   HALT  | frozen until reset
module bg_scroll_ctrl
  import bg_pkg::*;
#(
  parameter int         MAX_X          = MAX_X_DEF,
  parameter int         MAX_Y          = MAX_Y_DEF,
  parameter int         TWINKLE_FRAMES = 8,
  parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] hc,
  input  logic [9:0] vc,
  input  logic       start,
  input  logic       pause,
  input  logic       game_over,
  input  logic [2:0] speed,
  output logic [9:0] hc_out,
  output logic [9:0] vc_out,
  output logic [7:0] twinkle_mask,
  output logic       frame_tick,
  output logic [2:0] state_out
);

  if (MAX_X < 1 || MAX_X > 1024 || MAX_Y < 8 || MAX_Y > 1023) begin : g_bad_geom
    $error("bg_scroll_ctrl: screen geometry out of range");
  end
  if (TWINKLE_FRAMES < 1 || TWINKLE_FRAMES > 255 || LFSR_SEED == 8'h00) begin : g_bad_twinkle
    $error("bg_scroll_ctrl: invalid twinkle configuration");
  end

  localparam logic [10:0] MAX_Y_W = 11'(MAX_Y);

  bg_state_e   state, state_nxt;
  logic [9:0]  offset, offset_nxt;
  logic [2:0]  speed_cur, speed_nxt;
  logic [7:0]  lfsr, lfsr_nxt;
  logic [2:0]  step;
  logic [10:0] sum;
  logic [10:0] vc_sum;
  logic [9:0]  vc_map;
  logic        twinkle_step;

  bg_frame_sync #(
    .MAX_Y          (MAX_Y),
    .TWINKLE_FRAMES (TWINKLE_FRAMES)
  ) u_frame_sync (
    .clk          (clk),
    .rst          (rst),
    .hc           (hc),
    .vc           (vc),
    .run          (state == ST_RUN),
    .frame_tick   (frame_tick),
    .twinkle_step (twinkle_step)
  );

  always_comb begin
    state_nxt = state;
    speed_nxt = speed_cur;
    lfsr_nxt  = lfsr;
    step      = 3'd0;
    if (frame_tick) begin
      unique case (state)
        ST_IDLE: begin
          if (start) state_nxt = ST_RUN;
        end
        ST_RUN: begin
          speed_nxt = speed;
          step      = speed;
          if (twinkle_step) lfsr_nxt = lfsr_next(lfsr);
          if (game_over)  state_nxt = ST_DECEL;
          else if (pause) state_nxt = ST_PAUSE;
        end
        ST_PAUSE: begin
          if (game_over)   state_nxt = ST_DECEL;
          else if (!pause) state_nxt = ST_RUN;
        end
        ST_DECEL: begin
          step = speed_cur;
          if (speed_cur == 3'd0) state_nxt = ST_HALT;
          else                   speed_nxt = speed_cur - 3'd1;
        end
        default: ;
      endcase
    end
    sum        = {1'b0, offset} + {8'd0, step};
    offset_nxt = (sum >= MAX_Y_W) ? 10'(sum - MAX_Y_W) : sum[9:0];
  end

  // Blanking lines pass through untouched so downstream sync timing is unaffected.
  always_comb begin
    vc_sum = {1'b0, vc} + {1'b0, offset};
    if ({1'b0, vc} < MAX_Y_W) begin
      vc_map = (vc_sum >= MAX_Y_W) ? 10'(vc_sum - MAX_Y_W) : vc_sum[9:0];
    end else begin
      vc_map = vc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      offset    <= 10'd0;
      speed_cur <= 3'd0;
      lfsr      <= LFSR_SEED;
      hc_out    <= 10'd0;
      vc_out    <= 10'd0;
    end else begin
      state     <= state_nxt;
      offset    <= offset_nxt;
      speed_cur <= speed_nxt;
      lfsr      <= lfsr_nxt;
      hc_out    <= hc;
      vc_out    <= vc_map;
    end
  end

  assign twinkle_mask = lfsr;
  assign state_out    = state;

endmodule

// File: tb/tb_bg_scroll_ctrl.sv
// Randomised bench for bg_scroll_ctrl against a frame-level reference model.
module tb_bg_scroll_ctrl;

  localparam int         MAXY = 480;
  localparam int         TF   = 8;
  localparam logic [7:0] SEED = 8'hA5;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] hc, vc;
  logic       start, pause, game_over;
  logic [2:0] speed;
  logic [9:0] hc_out, vc_out;
  logic [7:0] twinkle_mask;
  logic       frame_tick;
  logic [2:0] state_out;

  always #5 clk = ~clk;

  bg_scroll_ctrl #(
    .MAX_X(640), .MAX_Y(MAXY), .TWINKLE_FRAMES(TF), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .hc(hc), .vc(vc), .start(start), .pause(pause),
    .game_over(game_over), .speed(speed), .hc_out(hc_out), .vc_out(vc_out),
    .twinkle_mask(twinkle_mask), .frame_tick(frame_tick), .state_out(state_out)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: frame-level state (0 idle,1 run,2 pause,3 decel,4 halt)
  int m_state, m_off, m_spd, m_run_ticks, m_lfsr;
  bit m_tick, m_cond_d;
  int e_hc, e_vc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic int lf(input int l);
    int nb;
    nb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
    return ((l << 1) | nb) & 255;
  endfunction

  task automatic apply_frame();
    case (m_state)
      0: if (start) m_state = 1;
      1: begin
        m_spd = int'(speed);
        m_off = (m_off + m_spd) % MAXY;
        m_run_ticks++;
        if (m_run_ticks % TF == 0) m_lfsr = lf(m_lfsr);
        if (game_over) m_state = 3;
        else if (pause) m_state = 2;
      end
      2: if (game_over) m_state = 3; else if (!pause) m_state = 1;
      3: begin
        m_off = (m_off + m_spd) % MAXY;
        if (m_spd == 0) m_state = 4; else m_spd--;
      end
      default: ;
    endcase
  endtask

  task automatic model_edge();
    bit cond;
    if (rst) begin
      m_state = 0; m_off = 0; m_spd = 0; m_run_ticks = 0; m_lfsr = int'(SEED);
      m_tick = 0; m_cond_d = 0; e_hc = 0; e_vc = 0;
    end else begin
      e_hc = int'(hc);
      e_vc = (vc < MAXY) ? (int'(vc) + m_off) % MAXY : int'(vc);
      if (m_tick) apply_frame();
      cond = (hc == 0) && (vc == MAXY);
      m_tick = cond && !m_cond_d;
      m_cond_d = cond;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("hc_out", 32'(hc_out), 32'(e_hc));
    chk("vc_out", 32'(vc_out), 32'(e_vc));
    chk("frame_tick", 32'(frame_tick), 32'(m_tick));
    chk("state_out", 32'(state_out), 32'(m_state));
    chk("twinkle_mask", 32'(twinkle_mask), 32'(m_lfsr));
  endtask

  task automatic drive(input int h, input int v);
    hc = 10'(h);
    vc = 10'(v);
    tick();
  endtask

  task automatic frame(input int nvis);
    repeat (nvis) drive($urandom_range(0, 639), $urandom_range(0, MAXY - 1));
    drive(5, MAXY);
    repeat ($urandom_range(1, 3)) drive(0, MAXY);
    drive(0, 500);
    drive($urandom_range(1, 799), $urandom_range(MAXY + 1, 524));
  endtask

  // Offset is observable as vc_out for line 0.
  task automatic probe_off(output int o);
    drive(17, 0);
    o = int'(vc_out);
  endtask

  int o0, o1, o2, g_prev, m0;
  int gains[5] = '{3, 3, 2, 1, 0};
  int dec_states[5] = '{3, 3, 3, 3, 4};

  initial begin
    rst = 1'b1; hc = '0; vc = '0; start = 0; pause = 0; game_over = 0; speed = '0;
    repeat (3) tick();
    chk("reset_mask", 32'(twinkle_mask), 32'h00A5);
    rst = 1'b0;

    // reset mid-frame, then idle frames
    drive(30, 100);
    rst = 1'b1; drive(100, 200); rst = 1'b0;
    chk("rst_mid_state", 32'(state_out), 32'd0);
    repeat (3) frame(3);
    probe_off(o0);
    chk("idle_offset", 32'(o0), 32'd0);

    // run at speed 7 until wrap: 1 start tick + 69 run ticks -> 483-480 = 3
    start = 1; speed = 3'd7;
    repeat (70) frame(2);
    start = 0;
    probe_off(o0);
    chk("wrap_offset", 32'(o0), 32'd3);
    drive(12, 478);
    chk("wrap_vc478", 32'(vc_out), 32'd1);
    drive(12, 500);
    chk("blank_vc500", 32'(vc_out), 32'd500);

    // mid-frame speed change
    speed = 3'd2;
    frame(2);
    probe_off(o1);
    drive(40, 50);
    speed = 3'd5;
    drive(40, 100);
    chk("midframe_map", 32'(vc_out), 32'((100 + o1) % MAXY));
    frame(3);
    probe_off(o2);
    chk("speed5_step", 32'((o2 - o1 + MAXY) % MAXY), 32'd5);

    // pause: the pausing tick still advances, then frozen
    speed = 3'd4; pause = 1;
    frame(2);
    chk("pause_state", 32'(state_out), 32'd2);
    probe_off(o1); m0 = int'(twinkle_mask);
    for (int i = 0; i < 4; i++) begin
      speed = 3'($urandom_range(0, 7));
      frame(2);
      probe_off(o2);
      chk("pause_offset", 32'(o2), 32'(o1));
      chk("pause_mask", 32'(twinkle_mask), 32'(m0));
    end
    pause = 0; speed = 3'd4;
    frame(2);
    chk("resume_state", 32'(state_out), 32'd1);
    frame(2);
    probe_off(o2);
    chk("resume_step", 32'((o2 - o1 + MAXY) % MAXY), 32'd4);

    // game over + pause together: decel wins
    speed = 3'd3;
    frame(2);
    probe_off(g_prev);
    game_over = 1; pause = 1;
    for (int i = 0; i < 5; i++) begin
      frame(1);
      speed = 3'd7;
      probe_off(o2);
      chk("decel_gain", 32'((o2 - g_prev + MAXY) % MAXY), 32'(gains[i]));
      chk("decel_state", 32'(state_out), 32'(dec_states[i]));
      g_prev = o2;
    end
    game_over = 0;
    for (int i = 0; i < 4; i++) begin
      start = 1'(i); pause = 1'(~i[0]);
      frame(2);
      probe_off(o2);
      chk("halt_state", 32'(state_out), 32'd4);
      chk("halt_offset", 32'(o2), 32'(g_prev));
    end
    start = 0; pause = 0;

    // twinkle cadence from reset
    rst = 1; drive(3, 3); rst = 0;
    start = 1;
    frame(2);
    for (int k = 1; k <= 16; k++) begin
      speed = 3'($urandom_range(0, 7));
      frame(1);
      if (k == 7)  chk("twk_7",  32'(twinkle_mask), 32'(SEED));
      if (k == 8)  chk("twk_8",  32'(twinkle_mask), 32'(lf(int'(SEED))));
      if (k == 15) chk("twk_15", 32'(twinkle_mask), 32'(lf(int'(SEED))));
      if (k == 16) chk("twk_16", 32'(twinkle_mask), 32'(lf(lf(int'(SEED)))));
    end

    // random soak
    for (int f = 0; f < 150; f++) begin
      speed     = 3'($urandom_range(0, 7));
      start     = ($urandom_range(0, 3) != 0);
      pause     = ($urandom_range(0, 3) == 0);
      game_over = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 50) == 0) begin
        drive($urandom_range(0, 639), $urandom_range(0, MAXY - 1));
        rst = 1; drive($urandom_range(0, 639), $urandom_range(0, 524)); rst = 0;
      end
      frame($urandom_range(1, 5));
      chk("mask_nonzero", 32'(twinkle_mask != 8'h00), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
